mul_div_unit: RTL and testbench

- Iterative multiply/divide unit in the Execute stage of the 32-bit MIPS pipeline. Owns the HI/LO registers.
- It sits at the other end of the stall/flush interface. It produces the Busy request that the hazard unit turns into StallF/StallD. It consumes FlushE to qualify incoming operations.
- Executes MULT, MULTU, DIV and DIVU. Supports MTHI/MTLO writes. Exposes HI/LO to the Writeback mux for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_div_iter.sv | 58 +++++
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encoding and the divide-by-zero LO value.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIX  = 2'b11
  } state_e;

  // LO result of a divide by zero: all ones (truncated to the datapath width).
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring-divide datapath: unsigned magnitudes only, one quotient bit per
// step. load captures dividend/divisor; step performs one shift-subtract.
module mdu_div_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quot,
  output logic [DATA_WIDTH-1:0] rem
);

  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;

  // Shift the next dividend bit into the partial remainder and subtract when it fits.
  always_comb begin
    shifted = {rem_q, quot_q[DATA_WIDTH-1]};
    fits    = shifted >= {1'b0, dsr_q};
    // When it fits the difference is below 2^DATA_WIDTH, so the low bits are exact.
    diff    = shifted[DATA_WIDTH-1:0] - dsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsr_d   = dsr_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dsr_d  = divisor;
    end else if (step) begin
      rem_d  = fits ? diff : shifted[DATA_WIDTH-1:0];
      quot_d = {quot_q[DATA_WIDTH-2:0], fits};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Operands are reduced to
// magnitudes at accept; sign is reapplied in FIX when HI/LO are committed.
// Optional macro FAST_MUL_EN: single-cycle multiplier, MUL state skipped.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE,
  input  logic [1:0]            OpE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic                  FlushE,
  input  logic                  WriteHiE,
  input  logic                  WriteLoE,
  output logic                  BusyE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] HiOut,
  output logic [DATA_WIDTH-1:0] LoOut
);
  import mdu_pkg::*;

  localparam int W = DATA_WIDTH;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic                 neg_res_q, neg_res_d;  // product/quotient must be negated
  logic                 neg_rem_q, neg_rem_d;  // dividend was negative
  logic                 div0_q, div0_d;
  logic [W-1:0]         mag_a_q, mag_a_d;
  logic [2*W-1:0]       acc_q, acc_d;          // {partial product, remaining multiplier bits}
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic         op_signed, a_neg, b_neg, accept, start_div;
  logic [W-1:0] mag_a, mag_b, quot, rem;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] prod_s;
  logic [W-1:0] quot_s, rem_s;
  logic         div_load, div_step;

  // Operand magnitudes and the FIX-stage signed results.
  always_comb begin
    op_signed = (OpE == OP_MULT) || (OpE == OP_DIV);
    a_neg     = op_signed & SrcAE[W-1];
    b_neg     = op_signed & SrcBE[W-1];
    mag_a     = a_neg ? -SrcAE : SrcAE;
    mag_b     = b_neg ? -SrcBE : SrcBE;
    accept    = StartE & ~FlushE & (state_q == IDLE);
    start_div = OpE[1];
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    prod_s    = neg_res_q ? -acc_q : acc_q;
    quot_s    = neg_res_q ? -quot : quot;
    rem_s     = neg_rem_q ? -rem : rem;
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mag_a_d   = mag_a_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = op_e'(OpE);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (SrcBE == '0);
          mag_a_d   = mag_a;
          cnt_d     = CNT_WIDTH'(W);
          if (start_div) begin
            div_load = 1'b1;
            state_d  = DIV;
          end else begin
`ifdef FAST_MUL_EN
            acc_d   = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
            state_d = FIX;
`else
            acc_d   = {{W{1'b0}}, mag_b};
            state_d = MUL;
`endif
          end
        end else if (!FlushE) begin
          if (WriteHiE) hi_d = SrcAE;
          if (WriteLoE) lo_d = SrcAE;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = FIX;
      end
      DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
          // With a zero divisor the remainder path already holds |dividend|,
          // so restoring the dividend sign returns the dividend unchanged.
          hi_d = rem_s;
          lo_d = div0_q ? W'(DIV0_LO) : quot_s;
        end else begin
          hi_d = prod_s[2*W-1:W];
          lo_d = prod_s[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mag_a_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mag_a_q   <= mag_a_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  mdu_div_iter #(.DATA_WIDTH(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (quot),
    .rem      (rem)
  );

  assign BusyE = (state_q != IDLE);
  assign DoneE = done_q;
  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops,
// compared every cycle against an arithmetic reference model.
module tb_mul_div_unit;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0, rst = 1'b1;
  logic        StartE = 1'b0, FlushE = 1'b0, WriteHiE = 1'b0, WriteLoE = 1'b0;
  logic [1:0]  OpE = 2'b00;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic        BusyE, DoneE;
  logic [31:0] HiOut, LoOut;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .FlushE(FlushE), .WriteHiE(WriteHiE), .WriteLoE(WriteLoE),
    .BusyE(BusyE), .DoneE(DoneE), .HiOut(HiOut), .LoOut(LoOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    int          sa, sb;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); return 64'(p); end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op);
    return op[1] ? DIV_LAT : MUL_LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Reference model: one step per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (StartE && m_left > 0) begin
        errors++;
        $display("FAIL start_while_busy: StartE=1 while model busy (%0d cycles left)", m_left);
      end
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= pend_hi; m_lo <= pend_lo; m_done <= 1'b1;
        end
      end else if (StartE && !FlushE) begin
        {pend_hi, pend_lo} <= ref_op(OpE, SrcAE, SrcBE);
        m_left <= latency(OpE);
      end else if (!FlushE) begin
        if (WriteHiE) m_hi <= SrcAE;
        if (WriteLoE) m_lo <= SrcAE;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(BusyE), 32'(m_left > 0));
      chk("done", 32'(DoneE), 32'(m_done));
      chk("hi",   HiOut, m_hi);
      chk("lo",   LoOut, m_lo);
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mtlo_mid, output int busy_n, output int done_n);
    @(negedge clk);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    @(negedge clk);
    StartE = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (BusyE) busy_n++;
      if (DoneE) done_n++;
      if (!BusyE && done_n > 0) break;
      if (mtlo_mid && i == 4) begin
        WriteLoE = 1'b1; SrcAE = 32'h0BAD_F00D;
      end else begin
        WriteLoE = 1'b0;
      end
      @(negedge clk);
    end
    WriteLoE = 1'b0;
    $display("op=%0d a=%h b=%h -> busy=%0d done=%0d HI=%h LO=%h", op, a, b, busy_n, done_n, HiOut, LoOut);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          bn, dn, sel;
    logic [63:0] r;
    logic [31:0] a, b;

    // Pin the model against hand-computed results.
    r = ref_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    chk("model_multu", r[31:0] ^ r[63:32], 32'hFFFF_FFFE ^ 32'h1);
    r = ref_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("model_mult_lo", r[31:0], 32'hFFFF_FFF1);
    r = ref_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("model_div_hi", r[63:32], 32'hFFFF_FFFF);
    r = ref_op(2'b11, 32'd7, 32'd0);
    chk("model_divu0_hi", r[63:32], 32'd7);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(BusyE), 32'd0);
    chk("reset_done", 32'(DoneE), 32'd0);
    chk("reset_hi", HiOut, 32'd0);
    chk("reset_lo", LoOut, 32'd0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, bn, dn);
    chk("multu_busy_cycles", bn, 32'd33 - 32'(33 - MUL_LAT));
    chk("multu_done_pulses", dn, 32'd1);
    chk("multu_hi", HiOut, 32'h0000_0001);
    chk("multu_lo", LoOut, 32'hFFFF_FFFE);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, bn, dn);
    chk("mult_busy_cycles", bn, MUL_LAT);
    chk("mult_hi", HiOut, 32'hFFFF_FFFF);
    chk("mult_lo", LoOut, 32'hFFFF_FFF1);

    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, bn, dn);
    chk("div_busy_cycles", bn, 32'd33);
    chk("div_lo", LoOut, 32'hFFFF_FFFD);
    chk("div_hi", HiOut, 32'hFFFF_FFFF);

    do_op(2'b11, 32'd7, 32'd0, 1'b0, bn, dn);
    chk("divu0_busy_cycles", bn, 32'd33);
    chk("divu0_lo", LoOut, 32'hFFFF_FFFF);
    chk("divu0_hi", HiOut, 32'h0000_0007);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bn, dn);
    chk("div_ovf_lo", LoOut, 32'h8000_0000);
    chk("div_ovf_hi", HiOut, 32'h0000_0000);

    // Flushed start and flushed MTHI must leave everything untouched.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; OpE = 2'b11; SrcAE = 32'd9; SrcBE = 32'd3;
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    chk("flush_start_busy", 32'(BusyE), 32'd0);
    repeat (2) @(negedge clk);
    chk("flush_start_hi", HiOut, 32'h0000_0000);
    chk("flush_start_lo", LoOut, 32'h8000_0000);
    WriteHiE = 1'b1; FlushE = 1'b1; SrcAE = 32'h0000_1234;
    @(negedge clk);
    WriteHiE = 1'b0; FlushE = 1'b0;
    chk("flush_mthi_hi", HiOut, 32'h0000_0000);

    // MTLO in IDLE, then MTLO while busy.
    WriteLoE = 1'b1; SrcAE = 32'hA5A5_A5A5;
    @(negedge clk);
    WriteLoE = 1'b0;
    chk("mtlo_idle", LoOut, 32'hA5A5_A5A5);
    do_op(2'b11, 32'd1003, 32'd10, 1'b1, bn, dn);
    chk("mtlo_busy_lo", LoOut, 32'd100);
    chk("mtlo_busy_hi", HiOut, 32'd3);

    // Reset in the middle of a divide.
    @(negedge clk);
    StartE = 1'b1; OpE = 2'b11; SrcAE = 32'd50; SrcBE = 32'd3;
    @(negedge clk);
    StartE = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(BusyE), 32'd0);
    chk("midrst_hi", HiOut, 32'd0);
    chk("midrst_lo", LoOut, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b11, 32'd100, 32'd7, 1'b0, bn, dn);
    chk("after_rst_lo", LoOut, 32'd14);
    chk("after_rst_hi", HiOut, 32'd2);

    // Random traffic checked by the per-cycle compare process.
    repeat (60) begin
      sel = $urandom_range(0, 9);
      a = pick();
      b = pick();
      if (sel < 2) begin
        @(negedge clk);
        StartE = 1'b1; FlushE = 1'b1; OpE = 2'($urandom_range(0, 3)); SrcAE = a; SrcBE = b;
        @(negedge clk);
        StartE = 1'b0; FlushE = 1'b0;
        $display("flushed start a=%h b=%h", a, b);
      end else if (sel < 4) begin
        @(negedge clk);
        WriteHiE = 1'($urandom_range(0, 1)); WriteLoE = 1'($urandom_range(0, 1));
        FlushE = ($urandom_range(0, 3) == 0); SrcAE = a;
        @(negedge clk);
        $display("mthi/mtlo a=%h HI=%h LO=%h", a, HiOut, LoOut);
        WriteHiE = 1'b0; WriteLoE = 1'b0; FlushE = 1'b0;
      end else begin
        do_op(2'($urandom_range(0, 3)), a, b, 1'b0, bn, dn);
        chk("rand_done_pulses", dn, 32'd1);
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
